// File: rtl/line_check_scheduler.sv
// line_check_scheduler: shares one two-vertex line checker across the six tetrahedron edges of each pixel.
// Define EDGE_SKIP_DEGEN_EN to skip edges whose two endpoints coincide.
module line_check_scheduler #(
   parameter int CHK_LAT = 0,
   parameter int W       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_start,
   input  logic signed [W-1:0] vtx1_X,
   input  logic signed [W-1:0] vtx1_Y,
   input  logic signed [W-1:0] vtx2_X,
   input  logic signed [W-1:0] vtx2_Y,
   input  logic signed [W-1:0] vtx3_X,
   input  logic signed [W-1:0] vtx3_Y,
   input  logic signed [W-1:0] vtx4_X,
   input  logic signed [W-1:0] vtx4_Y,
   input  logic                px_valid,
   output logic                px_ready,
   input  logic signed [W-1:0] h_cnt_Q,
   input  logic signed [W-1:0] v_cnt_Q,
   output logic signed [W-1:0] chk_h,
   output logic signed [W-1:0] chk_v,
   output logic signed [W-1:0] chk_vtxA_X,
   output logic signed [W-1:0] chk_vtxA_Y,
   output logic signed [W-1:0] chk_vtxB_X,
   output logic signed [W-1:0] chk_vtxB_Y,
   input  logic                chk_onLine,
   output logic                mask_valid,
   input  logic                mask_ready,
   output logic [5:0]          onLine_mask,
   output logic                busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
   state_t state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [1:0] dcnt_q, dcnt_d;
   logic pend_q, pend_d, latch, accept;
   logic [5:0] mask_q, mask_d, skip_d, skip_i;
   logic [3:0] cur, cap, n0, n1;
   logic signed [W-1:0] h_q, h_d, v_q, v_d;
   logic signed [W-1:0] vx_q [4], vy_q [4], vx_d [4], vy_d [4], vx_in [4], vy_in [4];

   function automatic logic [1:0] end_a(input logic [2:0] i);
      return i < 3'd3 ? 2'd0 : i < 3'd5 ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [1:0] end_b(input logic [2:0] i);
      return i == 3'd0 ? 2'd1 : (i == 3'd1 || i == 3'd3) ? 2'd2 : 2'd3;
   endfunction

   // lowest non-skipped edge at or above from; bit 3 flags that one exists
   function automatic logic [3:0] next_edge(input logic [5:0] sk, input logic [2:0] from);
      next_edge = 4'd0;
      for (int i = 5; i >= 0; i--)
         if (i >= int'(from) && !sk[i]) next_edge = {1'b1, 3'(i)};
   endfunction

   assign vx_in = '{vtx1_X, vtx2_X, vtx3_X, vtx4_X};
   assign vy_in = '{vtx1_Y, vtx2_Y, vtx3_Y, vtx4_Y};
   assign px_ready = rst_n && state_q == IDLE && !pend_q;
   assign accept = px_valid && px_ready;
   assign latch = state_q == IDLE && (frame_start || pend_q);
   assign cur = {state_q == ISSUE, idx_q};

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         vx_d[k] = latch ? vx_in[k] : vx_q[k];
         vy_d[k] = latch ? vy_in[k] : vy_q[k];
      end
   end

`ifdef EDGE_SKIP_DEGEN_EN
   logic [5:0] degen_q;
   always_comb begin
      skip_d = '0;
      for (int k = 0; k < 6; k++)
         skip_d[k] = vx_d[end_a(3'(k))] == vx_d[end_b(3'(k))] && vy_d[end_a(3'(k))] == vy_d[end_b(3'(k))];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) degen_q <= '0;
      else degen_q <= skip_d;
   assign skip_i = degen_q;
`else
   assign skip_d = '0;
   assign skip_i = '0;
`endif

   always_comb begin
      n0 = next_edge(skip_d, 3'd0);
      n1 = next_edge(skip_i, idx_q + 3'd1);
      state_d = state_q;
      idx_d = idx_q;
      dcnt_d = dcnt_q;
      h_d = h_q;
      v_d = v_q;
      mask_d = mask_q;
      pend_d = state_q == IDLE ? 1'b0 : pend_q || frame_start;
      if (cap[3]) mask_d[cap[2:0]] = chk_onLine;
      case (state_q)
         IDLE: if (accept) begin
            h_d = h_cnt_Q;
            v_d = v_cnt_Q;
            mask_d = '0;
            idx_d = n0[2:0];
            state_d = n0[3] ? ISSUE : HOLD;
         end
         ISSUE: begin
            idx_d = n1[3] ? n1[2:0] : idx_q;
            dcnt_d = '0;
            state_d = n1[3] ? ISSUE : CHK_LAT == 0 ? HOLD : DRAIN;
         end
         DRAIN: begin
            dcnt_d = dcnt_q + 2'd1;
            state_d = dcnt_q == 2'(CHK_LAT - 1) ? HOLD : DRAIN;
         end
         default: state_d = mask_ready ? IDLE : HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q <= '0;
         dcnt_q <= '0;
         pend_q <= 1'b0;
         mask_q <= '0;
         h_q <= '0;
         v_q <= '0;
         for (int k = 0; k < 4; k++) begin
            vx_q[k] <= '0;
            vy_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         dcnt_q <= dcnt_d;
         pend_q <= pend_d;
         mask_q <= mask_d;
         h_q <= h_d;
         v_q <= v_d;
         for (int k = 0; k < 4; k++) begin
            vx_q[k] <= vx_d[k];
            vy_q[k] <= vy_d[k];
         end
      end

   // {valid, idx} travels alongside the operands so results land in the right mask bit
   generate
      if (CHK_LAT == 0) begin : g_comb
         assign cap = cur;
      end else begin : g_pipe
         logic [3:0] sr_q [CHK_LAT], sr_d [CHK_LAT];
         always_comb begin
            sr_d[0] = cur;
            for (int i = 1; i < CHK_LAT; i++) sr_d[i] = sr_q[i-1];
         end
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) for (int i = 0; i < CHK_LAT; i++) sr_q[i] <= '0;
            else for (int i = 0; i < CHK_LAT; i++) sr_q[i] <= sr_d[i];
         assign cap = sr_q[CHK_LAT-1];
      end
   endgenerate

   assign chk_h = h_q;
   assign chk_v = v_q;
   assign chk_vtxA_X = vx_q[end_a(idx_q)];
   assign chk_vtxA_Y = vy_q[end_a(idx_q)];
   assign chk_vtxB_X = vx_q[end_b(idx_q)];
   assign chk_vtxB_Y = vy_q[end_b(idx_q)];
   assign mask_valid = state_q == HOLD;
   assign onLine_mask = mask_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_line_check_scheduler.sv
// tb_line_check_scheduler: scoreboarded random/directed bench with a collinearity checker model.
module tb_line_check_scheduler;
   localparam int W = 16;
   localparam int LAT = 2;

   logic clk = 0, rst_n = 0, frame_start = 0, px_valid = 0, mask_ready = 0;
   logic signed [W-1:0] vx [4], vy [4];
   logic signed [W-1:0] h_in = 0, v_in = 0;
   logic px_ready, chk_onLine, mask_valid, busy;
   logic signed [W-1:0] chk_h, chk_v, chk_vtxA_X, chk_vtxA_Y, chk_vtxB_X, chk_vtxB_Y;
   logic [5:0] onLine_mask;

   typedef struct {logic [5:0] mask; int acc;} exp_t;
   exp_t sb [$];
   int checks = 0, fails = 0, cyc = 0;
   bit seen = 0, rnd_rdy = 0, rdy_val = 1;
   longint mx [4], my [4];
   int ea_t [6] = '{0, 0, 0, 1, 1, 2};
   int eb_t [6] = '{1, 2, 3, 2, 3, 3};
   logic ol_pipe [LAT];

   line_check_scheduler #(.CHK_LAT(LAT), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .vtx1_X(vx[0]), .vtx1_Y(vy[0]), .vtx2_X(vx[1]), .vtx2_Y(vy[1]),
      .vtx3_X(vx[2]), .vtx3_Y(vy[2]), .vtx4_X(vx[3]), .vtx4_Y(vy[3]),
      .px_valid(px_valid), .px_ready(px_ready), .h_cnt_Q(h_in), .v_cnt_Q(v_in),
      .chk_h(chk_h), .chk_v(chk_v), .chk_vtxA_X(chk_vtxA_X), .chk_vtxA_Y(chk_vtxA_Y),
      .chk_vtxB_X(chk_vtxB_X), .chk_vtxB_Y(chk_vtxB_Y), .chk_onLine(chk_onLine),
      .mask_valid(mask_valid), .mask_ready(mask_ready), .onLine_mask(onLine_mask), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic on_seg(input longint h, v, ax, ay, bx, by);
      longint cr;
      cr = (bx - ax) * (v - ay) - (by - ay) * (h - ax);
      return cr == 0 && h >= (ax < bx ? ax : bx) && h <= (ax < bx ? bx : ax)
             && v >= (ay < by ? ay : by) && v <= (ay < by ? by : ay);
   endfunction

   function automatic logic [5:0] model_mask(input longint h, v);
      logic [5:0] m;
      for (int k = 0; k < 6; k++)
         m[k] = on_seg(h, v, mx[ea_t[k]], my[ea_t[k]], mx[eb_t[k]], my[eb_t[k]]);
      return m;
   endfunction

   // pipelined checker environment: answers LAT cycles after operands
   always @(posedge clk) begin
      ol_pipe[0] <= on_seg(chk_h, chk_v, chk_vtxA_X, chk_vtxA_Y, chk_vtxB_X, chk_vtxB_Y);
      for (int i = 1; i < LAT; i++) ol_pipe[i] <= ol_pipe[i-1];
   end
   assign chk_onLine = ol_pipe[LAT-1];

   always @(posedge clk) begin
      #1;
      mask_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() == 0) check("spurious_mask_valid", mask_valid, 0);
         else if (mask_valid) begin
            check("mask", onLine_mask, sb[0].mask);
            check("px_ready_in_hold", px_ready, 0);
            if (!seen) begin
               seen = 1;
               check("latency", cyc - sb[0].acc + 1, 7 + LAT);
            end
            if (mask_ready) begin
               void'(sb.pop_front());
               seen = 0;
            end
         end
      end
   end

   task automatic set_vtx(input int x0, y0, x1, y1, x2, y2, x3, y3);
      vx[0] = W'(x0); vy[0] = W'(y0); vx[1] = W'(x1); vy[1] = W'(y1);
      vx[2] = W'(x2); vy[2] = W'(y2); vx[3] = W'(x3); vy[3] = W'(y3);
   endtask

   task automatic commit();
      for (int k = 0; k < 4; k++) begin
         mx[k] = vx[k];
         my[k] = vy[k];
      end
   endtask

   task automatic do_pixel(input int h, v, input bit fs, output int acc);
      @(posedge clk); #1;
      px_valid = 1; h_in = W'(h); v_in = W'(v); acc = -1;
      for (int t = 0; t < 200 && acc < 0; t++) begin
         @(negedge clk);
         if (px_ready) begin
            if (fs) begin
               frame_start = 1;
               commit();
            end
            @(posedge clk); #1;
            acc = cyc; px_valid = 0; frame_start = 0;
            sb.push_back('{mask: model_mask(h, v), acc: acc});
         end
      end
      if (acc < 0) begin
         check("accept_timeout", px_ready, 1);
         px_valid = 0;
      end
   endtask

   task automatic wait_idle();
      int t;
      for (t = 0; t < 300 && (sb.size() != 0 || busy); t++) @(negedge clk);
      if (t == 300) check("drain_timeout", sb.size(), 0);
   endtask

   task automatic frame_idle();
      int t;
      @(negedge clk);
      for (t = 0; t < 300 && busy; t++) @(negedge clk);
      if (t == 300) check("frame_idle_timeout", busy, 0);
      frame_start = 1;
      commit();
      @(posedge clk); #1;
      frame_start = 0;
   endtask

   initial begin
      int a0, a1, a2, t;
      set_vtx(0, 0, 0, 0, 0, 0, 0, 0);
      commit();
      repeat (3) @(posedge clk);
      #1;
      check("rst_px_ready", px_ready, 0);
      check("rst_mask_valid", mask_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_mask", onLine_mask, 0);
      check("rst_chk_h", chk_h, 0);
      check("rst_chk_vtxB_X", chk_vtxB_X, 0);
      @(posedge clk); #2 rst_n = 1;
      @(negedge clk);
      check("px_ready_after_release", px_ready, 1);

      set_vtx(0, 0, 10, 0, 0, 10, 10, 10);
      frame_idle();
      do_pixel(5, 0, 0, a0);
      do_pixel(15, 0, 0, a0);
      do_pixel(10, 10, 0, a0);
      do_pixel(5, 5, 0, a0);
      do_pixel(5, 5, 0, a1);
      do_pixel(5, 5, 0, a2);
      check("throughput_0", a1 - a0, 8 + LAT);
      check("throughput_1", a2 - a1, 8 + LAT);
      wait_idle();

      rdy_val = 0;
      do_pixel(0, 5, 0, a0);
      for (t = 0; t < 50 && !mask_valid; t++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("hold_mask_valid", mask_valid, 1);
      rdy_val = 1;
      wait_idle();

      do_pixel(5, 5, 0, a0);
      @(posedge clk); #1;
      set_vtx(1, 1, 11, 1, 1, 11, 11, 11);
      frame_start = 1;
      @(posedge clk); #1;
      frame_start = 0;
      commit();
      @(negedge clk);
      for (t = 0; t < 50 && busy; t++) @(negedge clk);
      check("pending_latch_ready_low", px_ready, 0);
      @(negedge clk);
      check("pending_latch_ready_back", px_ready, 1);
      do_pixel(6, 1, 0, a0);
      wait_idle();

      set_vtx(2, 2, 2, 9, 9, 2, -3, -3);
      do_pixel(2, 5, 1, a0);
      wait_idle();

      do_pixel(5, 5, 0, a0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      check("midrst_mask_valid", mask_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_px_ready", px_ready, 0);
      check("midrst_chk_h", chk_h, 0);
      check("midrst_chk_vtxA_Y", chk_vtxA_Y, 0);
      sb.delete();
      seen = 0;
      set_vtx(0, 0, 0, 0, 0, 0, 0, 0);
      commit();
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      check("midrst_ready_after_release", px_ready, 1);
      repeat (12) @(negedge clk);
      set_vtx(0, 0, 10, 0, 0, 10, 10, 10);
      frame_idle();
      do_pixel(5, 0, 0, a0);
      wait_idle();

      rnd_rdy = 1;
      for (int n = 0; n < 40; n++) begin
         int r, k;
         r = $urandom_range(0, 4);
         k = $urandom_range(0, 3);
         if (r == 0) begin
            set_vtx($urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6,
                    $urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6,
                    $urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6);
            frame_idle();
         end else if (r == 1) begin
            set_vtx($urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4,
                    $urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4,
                    $urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4);
            do_pixel($urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4, 1, a0);
         end else if (r == 2) begin
            do_pixel(int'(mx[k]), int'(my[k]), 0, a0);
         end else begin
            do_pixel($urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6, 0, a0);
         end
      end
      rnd_rdy = 0;
      rdy_val = 1;
      wait_idle();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/line_check_scheduler.md
Name: line_check_scheduler

Overview:
- Time-multiplexes one shared two-vertex line-check datapath across the six edges of a 4-vertex tetrahedron. Replaces six parallel checkers.
- Accepts one pixel coordinate per request and issues the six vertex pairs in fixed order. Collects each onLine result and returns a 6-bit edge-hit mask to the pixel colouring stage.
- Vertices are shadow-latched at frame start, so mid-frame updates never tear a pixel.

Parameters:
- CHK_LAT, 0: cycles from driving chk_* operands to a valid chk_onLine (0 = combinational checker; legal 0..3).
- W, 16: signed coordinate width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; request to latch vtx*_X/Y
- vtx1_X, vtx1_Y, vtx2_X, vtx2_Y, vtx3_X, vtx3_Y, vtx4_X, vtx4_Y  in  W each  signed projected vertex coordinates
- px_valid  in  1  pixel request valid
- px_ready  out  1  scheduler can accept a pixel
- h_cnt_Q, v_cnt_Q  in  W each  signed pixel coordinate, sampled on accept
- chk_h, chk_v  out  W each  pixel coordinate to the shared checker
- chk_vtxA_X, chk_vtxA_Y, chk_vtxB_X, chk_vtxB_Y  out  W each  current edge endpoints
- chk_onLine  in  1  checker result, CHK_LAT cycles after operands
- mask_valid  out  1  result mask valid
- mask_ready  in  1  consumer accepts mask
- onLine_mask  out  6  bit k = pixel lies on edge k
- busy  out  1  pixel in flight

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE. px_ready=0 while in reset, and 1 in the first cycle after release.
  - mask_valid=0, onLine_mask=0, busy=0.
  - All chk_* outputs and the shadow vertices = 0. Pending-latch flag cleared.
- Edge order, bit k of onLine_mask: 0=(1,2), 1=(1,3), 2=(1,4), 3=(2,3), 4=(2,4), 5=(3,4). The first vertex of each pair drives vtxA.
- States: IDLE -> ISSUE -> DRAIN -> HOLD -> IDLE.
  - IDLE: px_ready=1. A clock edge with px_valid&px_ready latches h/v into chk_h/chk_v, clears the mask, and moves to ISSUE with edge idx=0.
  - ISSUE: one edge per cycle, idx 0..5, driven on chk_vtx*. After idx 5, go to DRAIN, or straight to HOLD when CHK_LAT=0.
  - DRAIN: waits CHK_LAT cycles for in-flight results.
  - HOLD: mask_valid=1 until mask_valid&mask_ready, then IDLE.
- Result capture:
  - A CHK_LAT-deep shift register carries {valid, idx} alongside the issued operands.
  - chk_onLine is written into mask bit idx when the delayed valid is set.
  - chk_h/chk_v stay stable for the whole pixel.
- Latency: mask_valid rises 7+CHK_LAT cycles after the accept edge (CHK_LAT=0 gives 7).
  - Throughput: one pixel per 8+CHK_LAT cycles when mask_ready is held 1.
  - No new pixel is accepted while in HOLD; px_ready=0 outside IDLE.
- Vertex shadowing:
  - frame_start in IDLE latches all eight vertex inputs on that edge.
  - frame_start while busy sets a pending flag. Latching then happens on the cycle the FSM returns to IDLE, using the vertex inputs present on that cycle. px_ready is held 0 for that one cycle.
  - frame_start coinciding with a px accept in IDLE: latch first. The pixel uses the new vertices.
- busy=1 in ISSUE, DRAIN and HOLD.
- Arithmetic: none on coordinates; widths pass through unchanged. Signed values are never truncated.
- Reset mid-operation: returns immediately to the reset state. The in-flight pixel and pending latch are discarded, and no partial mask is emitted.

Optional Feature:
- Macro EDGE_SKIP_DEGEN_EN.
- Enabled:
  - At shadow latch, compute a 6-bit degenerate flag per edge (endpoints identical in X and Y).
  - ISSUE skips flagged edges (no checker cycle) and forces their mask bits to 0.
  - All-degenerate: go straight from accept to HOLD with mask 0. mask_valid rises at cycle 1+(non-degenerate edges)+CHK_LAT.
- Disabled: all six edges are always issued. Fixed latency of 7+CHK_LAT.

Test Plan:
- CHK_LAT=0; vertices (0,0),(10,0),(0,10),(10,10); pixel (5,0); model checker = exact integer collinearity within the segment bounding box -> onLine_mask=6'b000001, mask_valid at cycle 7.
- Same vertices; pixel (5,5), which lies on edges 2 and 3 -> mask=6'b001100. Back-to-back pixels with mask_ready=1 -> px_ready returns every 8 cycles.
- CHK_LAT=2; pixel (0,5) -> mask=6'b000010 at cycle 9. mask_ready held 0 for 5 cycles -> mask and mask_valid stable, px_ready=0.
- frame_start during ISSUE with new vertices shifted by +1 -> current pixel uses old vertices. The latch happens on return to IDLE (px_ready low 1 cycle), and the next pixel (6,1) hits edge 0.
- rst_n asserted at cycle 3 of ISSUE -> outputs zero asynchronously, and no mask_valid after release. The first post-reset accept completes normally.
- EDGE_SKIP_DEGEN_EN defined; vtx2=vtx1=(3,3) -> edge 0 skipped, bit 0=0, mask_valid at cycle 6 (CHK_LAT=0). All four vertices equal -> mask 0 at cycle 1.
